// File: rtl/edetect_multi.sv
// edetect_multi: per-channel synchroniser, debounce, rise/fall classification,
// sticky flags, saturating edge counters and a combined interrupt.  rev 1.0
`default_nettype none

module edetect_multi #(
   parameter int                NUM_CH      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter int                DEBOUNCE    = 4,
   parameter logic [NUM_CH-1:0] DEFAULT     = '0,
   parameter int                CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       val,
   input  logic [2*NUM_CH-1:0]     edge_mode,
   input  logic [NUM_CH-1:0]       sticky_clr,
   input  logic                    cnt_clr,
   output logic [NUM_CH-1:0]       level_out,
   output logic [2*NUM_CH-1:0]     edge_out,
   output logic [NUM_CH-1:0]       sticky,
   output logic [NUM_CH*CNT_W-1:0] edge_cnt,
   output logic                    irq
);

   localparam int               DB_W    = $clog2(DEBOUNCE + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_CH-1:0] sync_w;
   logic [NUM_CH-1:0] sticky_d;
   logic              irq_q;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_w = val;
   end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
               sync_q[j] <= DEFAULT;
            end
         end else begin
            sync_q[0] <= val;
            for (int j = 1; j < SYNC_STAGES; j++) begin
               sync_q[j] <= sync_q[j-1];
            end
         end
      end

      assign sync_w = sync_q[SYNC_STAGES-1];
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DB_W-1:0]  db_q, db_d;
      logic             lvl_q, lvl_d;
      logic             stk_q, stk_d;
      logic [1:0]       edg_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             rise, fall, qual;

      // A new level is accepted only after DEBOUNCE consecutive differing samples.
      always_comb begin
         db_d  = db_q;
         lvl_d = lvl_q;
         if (sync_w[i] == lvl_q) begin
            db_d = '0;
         end else if (db_q == DB_LAST) begin
            lvl_d = sync_w[i];
            db_d  = '0;
         end else begin
            db_d = db_q + DB_W'(1);
         end
      end

      assign rise  = lvl_d & ~lvl_q;
      assign fall  = ~lvl_d & lvl_q;
      assign qual  = (rise & edge_mode[2*i]) | (fall & edge_mode[2*i+1]);
      assign stk_d = qual | (stk_q & ~sticky_clr[i]);

      always_comb begin
         cnt_d = cnt_q;
         if (cnt_clr) begin
            cnt_d = qual ? CNT_W'(1) : '0;
         end else if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_q  <= '0;
            lvl_q <= DEFAULT[i];
            edg_q <= 2'b00;
            stk_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            db_q  <= db_d;
            lvl_q <= lvl_d;
            edg_q <= {fall, rise};
            stk_q <= stk_d;
            cnt_q <= cnt_d;
         end
      end

      assign sticky_d[i]                  = stk_d;
      assign level_out[i]                 = lvl_q;
      assign edge_out[2*i +: 2]           = edg_q;
      assign sticky[i]                    = stk_q;
      assign edge_cnt[i*CNT_W +: CNT_W]   = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |sticky_d;
      end
   end

   assign irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_edetect_multi.sv
// tb_edetect_multi: directed scenarios for edetect_multi (2 sync stages,
// debounce 4, 4-bit counters). rev 1.0
`default_nettype none

module tb_edetect_multi;

   localparam int NUM_CH = 8;
   localparam int CNT_W  = 4;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_CH-1:0]       val;
   logic [2*NUM_CH-1:0]     edge_mode;
   logic [NUM_CH-1:0]       sticky_clr;
   logic                    cnt_clr;
   logic [NUM_CH-1:0]       level_out;
   logic [2*NUM_CH-1:0]     edge_out;
   logic [NUM_CH-1:0]       sticky;
   logic [NUM_CH*CNT_W-1:0] edge_cnt;
   logic                    irq;

   int checks = 0;
   int errors = 0;

   edetect_multi #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (2),
      .DEBOUNCE    (4),
      .DEFAULT     (8'h00),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .val        (val),
      .edge_mode  (edge_mode),
      .sticky_clr (sticky_clr),
      .cnt_clr    (cnt_clr),
      .level_out  (level_out),
      .edge_out   (edge_out),
      .sticky     (sticky),
      .edge_cnt   (edge_cnt),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs set afterwards are seen at the following edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; val = '0; edge_mode = '0; sticky_clr = '0; cnt_clr = 1'b0;
      step(3);
      checks++; if (level_out !== 8'h00) begin errors++; $display("FAIL reset_level: got %h expected 00", level_out); end
      checks++; if (edge_out !== 16'h0000) begin errors++; $display("FAIL reset_edge: got %h expected 0000", edge_out); end
      checks++; if ({sticky, irq} !== 9'h000) begin errors++; $display("FAIL reset_sticky_irq: got %h expected 000", {sticky, irq}); end
      checks++; if (edge_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", edge_cnt); end
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_latency;
      edge_mode = 16'hFFFF;
      val[0] = 1'b1;
      step(5);
      checks++; if (level_out[0] !== 1'b0) begin errors++; $display("FAIL lat_early_level: got %b expected 0", level_out[0]); end
      step(1);
      checks++; if (level_out[0] !== 1'b1) begin errors++; $display("FAIL lat_level: got %b expected 1", level_out[0]); end
      checks++; if (edge_out !== 16'h0001) begin errors++; $display("FAIL lat_edge_rise: got %h expected 0001", edge_out); end
      checks++; if ({sticky[0], irq} !== 2'b11) begin errors++; $display("FAIL lat_sticky_irq: got %b expected 11", {sticky[0], irq}); end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd1) begin errors++; $display("FAIL lat_cnt: got %0d expected 1", edge_cnt[0 +: CNT_W]); end
      step(1);
      checks++; if (edge_out !== 16'h0000) begin errors++; $display("FAIL lat_edge_pulse: got %h expected 0000", edge_out); end
      val[0] = 1'b0;
      step(6);
      checks++; if (edge_out !== 16'h0002) begin errors++; $display("FAIL lat_edge_fall: got %h expected 0002", edge_out); end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd2) begin errors++; $display("FAIL lat_cnt_fall: got %0d expected 2", edge_cnt[0 +: CNT_W]); end
      sticky_clr[0] = 1'b1;
      step(1);
      sticky_clr[0] = 1'b0;
      checks++; if ({sticky[0], irq} !== 2'b00) begin errors++; $display("FAIL lat_sticky_clr: got %b expected 00", {sticky[0], irq}); end
   endtask

   task automatic test_glitch;
      bit seen = 1'b0;
      val[0] = 1'b1;
      step(3);
      val[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (edge_out[1:0] != 2'b00 || level_out[0]) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_reject: got %b expected 0", seen); end
      checks++; if ({sticky[0], edge_cnt[0 +: CNT_W]} !== 5'h02) begin errors++; $display("FAIL glitch_state: got %h expected 02", {sticky[0], edge_cnt[0 +: CNT_W]}); end
      val[0] = 1'b1;
      step(4);
      val[0] = 1'b0;
      step(2);
      checks++; if (edge_out[1:0] !== 2'd1) begin errors++; $display("FAIL glitch_pulse_rise: got %0d expected 1", edge_out[1:0]); end
      step(4);
      checks++; if (edge_out[1:0] !== 2'd2) begin errors++; $display("FAIL glitch_pulse_fall: got %0d expected 2", edge_out[1:0]); end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd4) begin errors++; $display("FAIL glitch_cnt: got %0d expected 4", edge_cnt[0 +: CNT_W]); end
   endtask

   task automatic test_mode_mask;
      edge_mode[3:2] = 2'b10;
      val[1] = 1'b1;
      step(6);
      checks++; if (edge_out !== 16'h0004) begin errors++; $display("FAIL mask_rise_edge: got %h expected 0004", edge_out); end
      checks++; if ({sticky[1], edge_cnt[CNT_W +: CNT_W]} !== 5'h00) begin errors++; $display("FAIL mask_rise_unqual: got %h expected 00", {sticky[1], edge_cnt[CNT_W +: CNT_W]}); end
      val[1] = 1'b0;
      step(6);
      checks++; if (edge_out !== 16'h0008) begin errors++; $display("FAIL mask_fall_edge: got %h expected 0008", edge_out); end
      checks++; if ({sticky[1], edge_cnt[CNT_W +: CNT_W]} !== 5'h11) begin errors++; $display("FAIL mask_fall_qual: got %h expected 11", {sticky[1], edge_cnt[CNT_W +: CNT_W]}); end
      edge_mode[3:2] = 2'b11;
   endtask

   task automatic test_clear_races;
      sticky_clr = 8'hFF;
      step(1);
      sticky_clr = '0;
      checks++; if ({sticky, irq} !== 9'h000) begin errors++; $display("FAIL clr_all_sticky: got %h expected 000", {sticky, irq}); end
      val[0] = 1'b1;
      step(5);
      sticky_clr[0] = 1'b1;
      step(1);
      sticky_clr[0] = 1'b0;
      checks++; if ({sticky[0], irq} !== 2'b11) begin errors++; $display("FAIL clr_race_set_wins: got %b expected 11", {sticky[0], irq}); end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd5) begin errors++; $display("FAIL clr_race_cnt: got %0d expected 5", edge_cnt[0 +: CNT_W]); end
      val[0] = 1'b0; step(6);
      val[0] = 1'b1; step(6);
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd7) begin errors++; $display("FAIL clr_cnt_pre: got %0d expected 7", edge_cnt[0 +: CNT_W]); end
      val[0] = 1'b0;
      step(5);
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      checks++; if (edge_out[1:0] !== 2'd2) begin errors++; $display("FAIL cnt_clr_edge: got %0d expected 2", edge_out[1:0]); end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd1) begin errors++; $display("FAIL cnt_clr_race: got %0d expected 1", edge_cnt[0 +: CNT_W]); end
      checks++; if (edge_cnt[CNT_W +: CNT_W] !== 4'd0) begin errors++; $display("FAIL cnt_clr_other_ch: got %0d expected 0", edge_cnt[CNT_W +: CNT_W]); end
   endtask

   task automatic test_saturation;
      for (int p = 0; p < 20; p++) begin
         val[0] = 1'b1; step(6);
         val[0] = 1'b0; step(6);
         if (p == 6) begin
            checks++; if (edge_cnt[0 +: CNT_W] !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", edge_cnt[0 +: CNT_W]); end
         end
      end
      checks++; if (edge_cnt[0 +: CNT_W] !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", edge_cnt[0 +: CNT_W]); end
   endtask

   task automatic test_multi_channel;
      val = 8'hF0;
      step(6);
      checks++; if (edge_out !== 16'h5500) begin errors++; $display("FAIL multi_edge: got %h expected 5500", edge_out); end
      checks++; if (level_out !== 8'hF0) begin errors++; $display("FAIL multi_level: got %h expected f0", level_out); end
   endtask

   task automatic test_async_reset;
      val = 8'h01;
      step(3);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (level_out !== 8'h00) begin errors++; $display("FAIL areset_level: got %h expected 00", level_out); end
      checks++; if ({edge_out, sticky, irq} !== 25'h0) begin errors++; $display("FAIL areset_flags: got %h expected 0", {edge_out, sticky, irq}); end
      checks++; if (edge_cnt !== 32'h0) begin errors++; $display("FAIL areset_cnt: got %h expected 0", edge_cnt); end
      step(2);
      rst_n = 1'b1;
      step(5);
      checks++; if (level_out !== 8'h00) begin errors++; $display("FAIL areset_early: got %h expected 00", level_out); end
      step(1);
      checks++; if ({level_out, edge_out} !== 24'h01_0001) begin errors++; $display("FAIL areset_rise: got %h expected 010001", {level_out, edge_out}); end
      checks++; if ({sticky, edge_cnt[0 +: CNT_W]} !== 12'h011) begin errors++; $display("FAIL areset_qual: got %h expected 011", {sticky, edge_cnt[0 +: CNT_W]}); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_mode_mask();
      test_clear_races();
      test_saturation();
      test_multi_channel();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/edetect_multi.md
Name: edetect_multi

Overview:
- Multi-channel successor to the single-bit edge detector used by the register map.
- Per channel: optional input synchroniser, debounce filter, registered rise/fall classification, per-channel edge-mode mask, sticky event flag, saturating edge counter.
- A combined interrupt is raised for the register map.
- Sits between raw status/GPIO-style inputs and register-map readback and interrupt logic.

Parameters:
- NUM_CH, 8, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel; 0 means the input is used directly (already synchronous).
- DEBOUNCE, 4, consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering).
- DEFAULT, 0, NUM_CH-bit reset level for synchroniser and filtered level, bit i for channel i.
- CNT_W, 16, width of each per-channel edge counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- val  in  NUM_CH  raw channel inputs
- edge_mode  in  2*NUM_CH  per channel [2i] qualify rising, [2i+1] qualify falling
- sticky_clr  in  NUM_CH  one-cycle clear pulse per sticky bit
- cnt_clr  in  1  one-cycle clear of all edge counters
- level_out  out  NUM_CH  debounced level
- edge_out  out  2*NUM_CH  per channel code: 0 none, 1 rise, 2 fall
- sticky  out  NUM_CH  latched qualified-event flags
- edge_cnt  out  NUM_CH*CNT_W  qualified-edge counters, channel i at [i*CNT_W +: CNT_W]
- irq  out  1  OR of sticky

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - synchroniser flops and level_out to DEFAULT
  - debounce counters, edge_out, sticky, edge_cnt and irq to 0
- Reset mid-debounce discards the partial count.
- Synchroniser output s_i equals val_i delayed by SYNC_STAGES edges.
- Debounce, evaluated each edge per channel, with counter width $clog2(DEBOUNCE+1):
  - If s_i == level_i: counter <= 0.
  - Else if counter == DEBOUNCE-1: level_i <= s_i and counter <= 0.
  - Else: counter <= counter+1.
- Latency: val_i stable at a new value from edge k onward updates level_out at edge k+SYNC_STAGES+DEBOUNCE-1.
- Any return to the old level before acceptance resets the counter; no edge is reported.
- edge_out is registered and changes at the same edge as level_out: 1 if level went 0->1, 2 if 1->0. It is held for exactly one cycle, then returns to 0. Code 3 never occurs.
- edge_out is not masked by edge_mode.
- Qualified edge: a rise with edge_mode[2i] set, or a fall with edge_mode[2i+1] set. edge_mode is sampled at the edge where level updates.
- Sticky:
  - A qualified edge sets sticky_i at the same edge as edge_out.
  - sticky_clr_i clears it.
  - If a clear and a qualified edge occur in the same cycle, set wins.
- Counter:
  - A qualified edge increments edge_cnt_i, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr zeroes all counters.
  - If cnt_clr coincides with a qualified edge, the counter becomes 1.
- irq is registered: irq <= OR of next-state sticky, so it rises and falls on the same edge as sticky.
- Reset release with val != DEFAULT: after SYNC_STAGES+DEBOUNCE edges an edge is reported normally, and is qualified per edge_mode.
- Channels are fully independent; simultaneous edges on several channels are all reported in the same cycle.

Test Plan:
1. Latency: SYNC_STAGES=2, DEBOUNCE=4, DEFAULT=0, edge_mode=2'b11. val[0] rises before edge 0 and holds -> level_out[0]=1 and edge_out[1:0]=1 after edge 5; edge_out=0 after edge 6; sticky[0]=1, irq=1, edge_cnt[0]=1.
2. Glitch rejection: val[0] high at edges 0..2 only (3 cycles < DEBOUNCE=4) -> level_out, edge_out, sticky and edge_cnt unchanged. Then a 4-cycle pulse -> one rise, then after a 4-cycle low one fall; edge_cnt[0]=2.
3. Mode masking: edge_mode ch1=2'b10, full high/low pulse on val[1] -> edge_out shows 1 then 2; edge_cnt[1]=1 and sticky[1] set only at the fall.
4. Clear races: sticky_clr[0] on the same cycle as a qualified edge -> sticky[0] stays 1. cnt_clr on a qualified-edge cycle with edge_cnt[0]=7 -> edge_cnt[0]=1. sticky_clr alone -> sticky 0, irq 0 next edge.
5. Saturation: CNT_W=4, 20 qualified pulses -> edge_cnt holds 15, no wrap.
6. Async reset: assert rst_n low mid-debounce, between clock edges -> all outputs at reset values immediately. Release with val[0]=1, DEFAULT=0 -> a rise is reported after SYNC_STAGES+DEBOUNCE edges.
